gon_bus_ctrl: RTL

Sequencer for the GLB-to-PE-array multicast bus.
- Configure phase: loads per-slave IDs serially and publishes them with a one-cycle ID-valid strobe.
- Run phase: forwards a GLB packet stream onto the bus and stamps each packet with the current tag. The tag steps through a programmed range after a programmed number of packets per tag.
- Sits between the top controller/GLB and the multicast bus.

---
 rtl/gon_bus_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gon_bus_ctrl.sv
// GLB-to-PE multicast bus sequencer.
// Loads slave IDs, then forwards tagged packets.
module gon_bus_ctrl #(
  parameter int ID_BITWIDTH     = 4,
  parameter int SLV_NUM         = 6,
  parameter int PACKET_BITWIDTH = 8,
  parameter int CNT_BITWIDTH    = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cfg_start,
  input  logic [ID_BITWIDTH-1:0]         i_cfg_id,
  input  logic                           i_cfg_id_valid,
  output logic [SLV_NUM*ID_BITWIDTH-1:0] o_id,
  output logic                           o_id_valid,
  input  logic                           i_run_start,
  input  logic [ID_BITWIDTH-1:0]         i_tag_first,
  input  logic [ID_BITWIDTH-1:0]         i_tag_num,
  input  logic [CNT_BITWIDTH-1:0]        i_pkt_per_tag,
  input  logic [PACKET_BITWIDTH-1:0]     i_src_packet,
  input  logic                           i_src_valid,
  output logic                           o_src_ready,
  output logic [PACKET_BITWIDTH-1:0]     o_bus_packet,
  output logic [ID_BITWIDTH-1:0]         o_bus_tag,
  output logic                           o_bus_valid,
  input  logic                           i_bus_ready,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CFG_FIN,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          cfg_idx;
  logic [SLV_NUM*ID_BITWIDTH-1:0] id_q;
  logic [ID_BITWIDTH-1:0]    bus_tag;
  logic [ID_BITWIDTH-1:0]    tag_idx;
  logic [ID_BITWIDTH-1:0]    tag_num_q;
  logic [CNT_BITWIDTH-1:0]   pkt_cnt;
  logic [CNT_BITWIDTH-1:0]   ppt_q;

  logic in_run;
  logic hs;
  logic last_pkt;
  logic last_tag;
  logic zero_run;
  logic cfg_last;
  logic cfg_wr;
  logic run_go;

  assign in_run   = (state == S_RUN);
  assign hs       = in_run & i_src_valid & i_bus_ready;
  assign last_pkt = (pkt_cnt == ppt_q - CNT_BITWIDTH'(1));
  assign last_tag = (tag_idx == tag_num_q - ID_BITWIDTH'(1));
  assign zero_run = (i_tag_num == '0) | (i_pkt_per_tag == '0);
  assign cfg_last = (cfg_idx == IDX_W'(SLV_NUM - 1));
  assign cfg_wr   = (state == S_CFG) & i_cfg_id_valid;
  assign run_go   = (state == S_IDLE) & ~i_cfg_start & i_run_start;

  assign o_id         = id_q;
  assign o_id_valid   = (state == S_CFG_FIN);
  assign o_done       = (state == S_DONE);
  assign o_busy       = (state != S_IDLE);
  assign o_bus_tag    = bus_tag;
  assign o_bus_packet = i_src_packet;
  assign o_bus_valid  = in_run & i_src_valid;
  assign o_src_ready  = in_run & i_bus_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: cfg start beats run start; final handshake ends the run.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (i_cfg_start)      state_nxt = S_CFG;
        else if (i_run_start) state_nxt = zero_run ? S_DONE : S_RUN;
      end
      S_CFG:     if (cfg_wr && cfg_last) state_nxt = S_CFG_FIN;
      S_CFG_FIN: state_nxt = S_IDLE;
      S_RUN:     if (hs && last_pkt && last_tag) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ID shift-in, run latch and packet/tag counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cfg_idx   <= '0;
      id_q      <= '0;
      bus_tag   <= '0;
      tag_idx   <= '0;
      tag_num_q <= '0;
      pkt_cnt   <= '0;
      ppt_q     <= '0;
    end else begin
      if (state == S_IDLE && i_cfg_start) cfg_idx <= '0;
      if (run_go) begin
        tag_num_q <= i_tag_num;
        ppt_q     <= i_pkt_per_tag;
        bus_tag   <= i_tag_first;
        pkt_cnt   <= '0;
        tag_idx   <= '0;
      end
      if (cfg_wr) begin
        for (int k = 0; k < SLV_NUM; k++) begin
          if (cfg_idx == IDX_W'(k))
            id_q[k*ID_BITWIDTH +: ID_BITWIDTH] <= i_cfg_id;
        end
        cfg_idx <= cfg_idx + IDX_W'(1);
      end
      if (hs) begin
        if (last_pkt) begin
          pkt_cnt <= '0;
          bus_tag <= bus_tag + ID_BITWIDTH'(1);
          tag_idx <= tag_idx + ID_BITWIDTH'(1);
        end else begin
          pkt_cnt <= pkt_cnt + CNT_BITWIDTH'(1);
        end
      end
    end
  end

endmodule
